// File: rtl/noc_params.sv
// Shared NoC types: flit format, flit labels, per-VC framing state, credit width helper.
package noc_params;
   localparam int DATA_W  = 16;
   localparam int VC_SIZE = 2;

   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

   typedef struct packed {
      flit_label_t          flit_label;
      logic [VC_SIZE-1:0]   vc_id;
      logic [DATA_W-1:0]    data;
   } flit_t;

   typedef enum logic {IDLE, IN_PACKET} vc_state_t;

   // Counter must hold 0..depth inclusive.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter for one VC; flags a return that arrives while already full.
module credit_counter
   import noc_params::*;
#(
   parameter int BUFFER_SIZE = 8,
   localparam int CREDIT_W = credit_width(BUFFER_SIZE)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dec_i,
   input  logic                inc_i,
   output logic [CREDIT_W-1:0] count_o,
   output logic                overflow_o
);
   localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(BUFFER_SIZE);

   logic [CREDIT_W-1:0] count_q;

   function automatic logic [CREDIT_W-1:0] sat_update(input logic [CREDIT_W-1:0] c,
                                                      input logic dec,
                                                      input logic inc);
      logic [CREDIT_W-1:0] r;
      r = c;
      if (inc && !dec && c != FULL)
         r = c + 1'b1;
      else if (dec && !inc && c != '0)
         r = c - 1'b1;
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst)
         count_q <= FULL;
      else
         count_q <= sat_update(count_q, dec_i, inc_i);
   end

   // No credits outstanding, so any return at full is a downstream bug.
   assign overflow_o = inc_i && (count_q == FULL);
   assign count_o    = count_q;
endmodule

// File: rtl/credit_tx.sv
// Credit-based flit transmitter: pops the local queue head when its VC has credit, registers it onto the link.
module credit_tx
   import noc_params::*;
#(
   parameter int VC_NUM      = 2,
   parameter int BUFFER_SIZE = 8,
   localparam int CREDIT_W   = credit_width(BUFFER_SIZE)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  flit_t                            data_i,
   input  logic                             is_empty_i,
   output logic                             read_o,
   output flit_t                            flit_o,
   output logic                             valid_flit_o,
   input  logic                             credit_valid_i,
   input  logic [VC_SIZE-1:0]               credit_vc_i,
   output logic [VC_NUM-1:0][CREDIT_W-1:0]  credit_o,
   output logic                             error_o
);
   logic [VC_NUM-1:0]                dec;
   logic [VC_NUM-1:0]                inc;
   logic [VC_NUM-1:0]                overflow;
   logic [VC_NUM-1:0][CREDIT_W-1:0]  count;
   vc_state_t                        vc_state [VC_NUM];
   logic                             head_has_credit;
   logic                             send;
   logic                             frame_err;
   logic                             credit_vc_bad;
   flit_t                            flit_p1;
   logic                             vld_p1;
   logic                             error_q;

   // Only the head flit's VC is consulted: no bypass around a stalled head.
   always_comb begin
      head_has_credit = 1'b0;
      frame_err       = 1'b0;
      dec             = '0;
      inc             = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         if (data_i.vc_id == VC_SIZE'(v) && count[v] != '0)
            head_has_credit = 1'b1;
      end
      send = !rst && !is_empty_i && head_has_credit;
      for (int v = 0; v < VC_NUM; v++) begin
         dec[v] = send && (data_i.vc_id == VC_SIZE'(v));
         inc[v] = credit_valid_i && (credit_vc_i == VC_SIZE'(v));
         if (dec[v]) begin
            if (vc_state[v] == IDLE)
               frame_err = (data_i.flit_label == BODY) || (data_i.flit_label == TAIL);
            else
               frame_err = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
         end
      end
      credit_vc_bad = credit_valid_i && (int'(credit_vc_i) >= VC_NUM);
   end

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      credit_counter #(.BUFFER_SIZE(BUFFER_SIZE)) u_cnt (
         .clk        (clk),
         .rst        (rst),
         .dec_i      (dec[v]),
         .inc_i      (inc[v]),
         .count_o    (count[v]),
         .overflow_o (overflow[v])
      );
   end

   // Stage p1: link register, sticky error and per-VC framing state.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         flit_p1 <= '0;
         error_q <= 1'b0;
         for (int v = 0; v < VC_NUM; v++)
            vc_state[v] <= IDLE;
      end else begin
         vld_p1 <= send;
         if (send)
            flit_p1 <= data_i;
         if (frame_err || credit_vc_bad || (|overflow))
            error_q <= 1'b1;
         for (int v = 0; v < VC_NUM; v++) begin
            if (dec[v]) begin
               if (vc_state[v] == IDLE && data_i.flit_label == HEAD)
                  vc_state[v] <= IN_PACKET;
               else if (vc_state[v] == IN_PACKET && data_i.flit_label == TAIL)
                  vc_state[v] <= IDLE;
            end
         end
      end
   end

   assign read_o       = send;
   assign flit_o       = flit_p1;
   assign valid_flit_o = vld_p1;
   assign credit_o     = count;
   assign error_o      = error_q;
endmodule

// File: tb/tb_credit_tx.sv
// Bench for credit_tx: directed test-plan scenarios plus a random phase against a queue/arithmetic model.
module tb_credit_tx;
   import noc_params::*;

   localparam int VC_NUM = 2;
   localparam int BUF    = 8;
   localparam int CW     = $clog2(BUF + 1);

   logic                        clk;
   logic                        rst;
   flit_t                       data_i;
   logic                        is_empty_i;
   logic                        read_o;
   flit_t                       flit_o;
   logic                        valid_flit_o;
   logic                        credit_valid_i;
   logic [VC_SIZE-1:0]          credit_vc_i;
   logic [VC_NUM-1:0][CW-1:0]   credit_o;
   logic                        error_o;

   credit_tx #(.VC_NUM(VC_NUM), .BUFFER_SIZE(BUF)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_i         (data_i),
      .is_empty_i     (is_empty_i),
      .read_o         (read_o),
      .flit_o         (flit_o),
      .valid_flit_o   (valid_flit_o),
      .credit_valid_i (credit_valid_i),
      .credit_vc_i    (credit_vc_i),
      .credit_o       (credit_o),
      .error_o        (error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_tests = 0;
   int    n_fail  = 0;
   flit_t q[$];
   logic  pop_now = 1'b0;

   // Reference model state, as seen after the most recent clock edge.
   int    m_cred [VC_NUM];
   bit    m_inpkt[VC_NUM];
   bit    m_err;
   bit    m_vld;
   flit_t m_flit;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic flit_t mk(input flit_label_t l, input int vc, input int d);
      flit_t f;
      f.flit_label = l;
      f.vc_id      = VC_SIZE'(vc);
      f.data       = DATA_W'(d);
      return f;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < VC_NUM; v++) begin
         m_cred[v]  = BUF;
         m_inpkt[v] = 1'b0;
      end
      m_err  = 1'b0;
      m_vld  = 1'b0;
      m_flit = '0;
   endtask

   // Compare process: registered outputs vs model, then read_o vs model, then advance model.
   initial begin
      bit    exp_send;
      bit    viol;
      flit_t f;
      int    vc;
      int    nc;
      model_reset();
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("valid_flit_o", 64'(valid_flit_o), 64'(m_vld));
         chk("flit_o", 64'(flit_o), 64'(m_flit));
         for (int v = 0; v < VC_NUM; v++)
            chk($sformatf("credit%0d", v), 64'(credit_o[v]), 64'(m_cred[v]));
         chk("error_o", 64'(error_o), 64'(m_err));

         f  = (q.size() > 0) ? q[0] : '0;
         vc = int'(f.vc_id);
         exp_send = !rst && (q.size() > 0) && (vc < VC_NUM) && (m_cred[vc % VC_NUM] > 0);
         chk("read_o", 64'(read_o), 64'(exp_send));
         pop_now = read_o;

         if (rst) begin
            model_reset();
         end else begin
            m_vld = exp_send;
            if (exp_send) begin
               m_flit = f;
               viol = m_inpkt[vc] ? (f.flit_label == HEAD || f.flit_label == HEADTAIL)
                                  : (f.flit_label == BODY || f.flit_label == TAIL);
               if (viol) m_err = 1'b1;
               else      m_inpkt[vc] = (f.flit_label == HEAD || f.flit_label == BODY);
            end
            for (int v = 0; v < VC_NUM; v++) begin
               nc = m_cred[v];
               if (exp_send && vc == v) nc--;
               if (credit_valid_i && int'(credit_vc_i) == v) begin
                  nc++;
                  if (m_cred[v] == BUF) m_err = 1'b1;
               end
               m_cred[v] = (nc > BUF) ? BUF : nc;
            end
            if (credit_valid_i && int'(credit_vc_i) >= VC_NUM) m_err = 1'b1;
         end
      end
   end

   task automatic refresh();
      if (q.size() > 0) begin
         data_i     = q[0];
         is_empty_i = 1'b0;
      end else begin
         data_i     = '0;
         is_empty_i = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (pop_now && q.size() > 0) void'(q.pop_front());
      credit_valid_i = 1'b0;
      refresh();
   endtask

   task automatic ret(input int vc);
      credit_valid_i = 1'b1;
      credit_vc_i    = VC_SIZE'(vc);
   endtask

   initial begin
      bit gen_inpkt[VC_NUM];
      flit_label_t l;
      int v;
      rst = 1'b1;
      credit_valid_i = 1'b0;
      credit_vc_i = '0;
      refresh();
      tick();
      tick();
      chk("rst_credit0", 64'(credit_o[0]), 64'd8);
      chk("rst_credit1", 64'(credit_o[1]), 64'd8);
      chk("rst_valid", 64'(valid_flit_o), 64'd0);
      chk("rst_error", 64'(error_o), 64'd0);
      chk("rst_flit", 64'(flit_o), 64'd0);
      rst = 1'b0;
      tick();

      // Burst drain on VC0.
      q.push_back(mk(HEAD, 0, 0));
      for (int i = 1; i < 7; i++) q.push_back(mk(BODY, 0, i));
      q.push_back(mk(TAIL, 0, 7));
      refresh();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("burst_valid", 64'(valid_flit_o), 64'd1);
         chk("burst_data", 64'(flit_o.data), 64'(i));
      end
      chk("burst_credit0", 64'(credit_o[0]), 64'd0);
      q.push_back(mk(HEADTAIL, 0, 8));
      refresh();
      #1;
      chk("stall_read", 64'(read_o), 64'd0);
      tick();
      chk("stall_valid", 64'(valid_flit_o), 64'd0);

      // Credit refill: return at t, read at t+1, flit at t+2.
      ret(0);
      tick();
      #1;
      chk("refill_read", 64'(read_o), 64'd1);
      chk("refill_credit", 64'(credit_o[0]), 64'd1);
      tick();
      chk("refill_valid", 64'(valid_flit_o), 64'd1);
      chk("refill_data", 64'(flit_o.data), 64'd8);
      chk("refill_credit0", 64'(credit_o[0]), 64'd0);
      chk("frame_ok_error", 64'(error_o), 64'd0);
      for (int i = 0; i < 8; i++) begin ret(0); tick(); end
      chk("vc0_full", 64'(credit_o[0]), 64'd8);

      // Simultaneous send and return on VC1 at count 3.
      q.push_back(mk(HEAD, 1, 100));
      for (int i = 1; i < 5; i++) q.push_back(mk(BODY, 1, 100 + i));
      refresh();
      for (int i = 0; i < 5; i++) tick();
      chk("vc1_at3", 64'(credit_o[1]), 64'd3);
      for (int i = 0; i < 5; i++) q.push_back(mk(BODY, 1, 200 + i));
      q.push_back(mk(TAIL, 1, 205));
      refresh();
      for (int i = 0; i < 6; i++) begin
         ret(1);
         tick();
         chk("simul_credit1", 64'(credit_o[1]), 64'd3);
         chk("simul_valid", 64'(valid_flit_o), 64'd1);
      end
      for (int i = 0; i < 5; i++) begin ret(1); tick(); end

      // Head-of-line stall: VC0 empty of credit blocks a VC1 flit behind it.
      for (int i = 0; i < 8; i++) q.push_back(mk(HEADTAIL, 0, 300 + i));
      refresh();
      for (int i = 0; i < 8; i++) tick();
      chk("hol_credit0", 64'(credit_o[0]), 64'd0);
      q.push_back(mk(HEADTAIL, 0, 'h55));
      q.push_back(mk(HEADTAIL, 1, 'h66));
      refresh();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hol_stall", 64'(valid_flit_o), 64'd0);
      end
      ret(0);
      tick();
      chk("hol_wait", 64'(valid_flit_o), 64'd0);
      tick();
      chk("hol_first", 64'(flit_o.data), 64'h55);
      tick();
      chk("hol_second", 64'(flit_o.data), 64'h66);
      chk("hol_second_vld", 64'(valid_flit_o), 64'd1);

      // Framing violation: BODY while VC0 is idle.
      ret(0);
      q.push_back(mk(BODY, 0, 'h77));
      refresh();
      tick();
      tick();
      chk("frame_bad_sent", 64'(valid_flit_o), 64'd1);
      chk("frame_bad_err", 64'(error_o), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frame_sticky", 64'(error_o), 64'd1);
      end

      // Overflow, bad VC id, and reset mid-burst.
      rst = 1'b1;
      tick();
      chk("clr_error", 64'(error_o), 64'd0);
      chk("clr_credit0", 64'(credit_o[0]), 64'd8);
      rst = 1'b0;
      ret(0);
      tick();
      chk("ovf_error", 64'(error_o), 64'd1);
      chk("ovf_credit0", 64'(credit_o[0]), 64'd8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ret(3);
      tick();
      chk("badvc_error", 64'(error_o), 64'd1);
      q.push_back(mk(HEAD, 1, 400));
      for (int i = 1; i < 6; i++) q.push_back(mk(BODY, 1, 400 + i));
      refresh();
      for (int i = 0; i < 3; i++) tick();
      chk("mid_valid", 64'(valid_flit_o), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_gates_read", 64'(read_o), 64'd0);
      tick();
      chk("mid_rst_valid", 64'(valid_flit_o), 64'd0);
      chk("mid_rst_credit1", 64'(credit_o[1]), 64'd8);
      chk("mid_rst_credit0", 64'(credit_o[0]), 64'd8);
      q.delete();
      rst = 1'b0;
      refresh();
      tick();

      // Random phase, periodic resets reopen the sticky error.
      for (int c = 0; c < 4000; c++) begin
         rst = (c % 500 == 499);
         if (rst) for (int k = 0; k < VC_NUM; k++) gen_inpkt[k] = 1'b0;
         if (q.size() < 6 && $urandom_range(0, 99) < 60) begin
            v = $urandom_range(0, VC_NUM - 1);
            if ($urandom_range(0, 99) == 0)
               l = flit_label_t'($urandom_range(0, 3));
            else if (gen_inpkt[v])
               l = ($urandom_range(0, 3) == 0) ? TAIL : BODY;
            else
               l = ($urandom_range(0, 2) == 0) ? HEADTAIL : HEAD;
            gen_inpkt[v] = (l == HEAD || l == BODY);
            q.push_back(mk(l, v, $urandom_range(0, 65535)));
            refresh();
         end
         if ($urandom_range(0, 299) == 0) begin
            ret($urandom_range(VC_NUM, 3));
         end else if ($urandom_range(0, 99) < 45) begin
            v = $urandom_range(0, VC_NUM - 1);
            if (m_cred[v] < BUF || $urandom_range(0, 63) == 0) ret(v);
         end
         tick();
      end
      rst = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
